i2c_target_byte_engine: RTL and testbench

I2C_TARGET_BYTE_ENGINE -- requirements
Module: i2c_target_byte_engine

---
 rtl/i2c_target_byte_engine.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_i2c_target_byte_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_byte_engine.sv
// I2C target byte engine: address match, write-byte delivery and read-byte serialisation.
// Optional SCL/SDA glitch filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_byte_engine #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int         DATA_LENGTH   = 8
) (
    input  logic                   pclk,
    input  logic                   areset,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_first,
    input  logic                   rx_ready,
    output logic                   rd_req,
    input  logic [DATA_LENGTH-1:0] rd_data,
    output logic                   busy,
    output logic                   read_write
);

    localparam int CNT_MAX = (DATA_LENGTH > 8) ? DATA_LENGTH : 8;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    logic scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
    logic scl_filt_s, sda_filt_s;
    logic scl_prev_r, sda_prev_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t                 state_r, state_nxt;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt;
    logic [6:0]             addr_sh_r, addr_sh_nxt;
    logic [DATA_LENGTH-2:0] rx_sh_r, rx_sh_nxt;
    logic [DATA_LENGTH-2:0] tx_sh_r, tx_sh_nxt;
    logic [7:0]             addr_byte_s;
    logic [DATA_LENGTH-1:0] rx_byte_s;
    logic                   sda_oe_r, sda_oe_nxt;
    logic [DATA_LENGTH-1:0] rx_data_r, rx_data_nxt;
    logic                   rx_valid_r, rx_valid_nxt;
    logic                   rx_first_r, rx_first_nxt;
    logic                   rd_req_r, rd_req_nxt;
    logic                   load_r, load_nxt;
    logic                   busy_r, busy_nxt;
    logic                   rw_r, rw_nxt;
    logic                   ack_phase_r, ack_phase_nxt;
    logic                   ack_en_r, ack_en_nxt;
    logic                   first_pend_r, first_pend_nxt;

    // Two-flop synchronisers for the raw bus lines, idle-high after reset.
    always_ff @(posedge pclk) begin
        if (areset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_r, sda_hist_r;
    logic       scl_held_r, sda_held_r;

    // A new level is accepted once three consecutive synchronised samples agree.
    assign scl_filt_s = ((scl_sync_r == scl_hist_r[0]) && (scl_sync_r == scl_hist_r[1])) ? scl_sync_r : scl_held_r;
    assign sda_filt_s = ((sda_sync_r == sda_hist_r[0]) && (sda_sync_r == sda_hist_r[1])) ? sda_sync_r : sda_held_r;

    // Sample history and held filter outputs.
    always_ff @(posedge pclk) begin
        if (areset) begin
            scl_hist_r <= 2'b11;
            sda_hist_r <= 2'b11;
            scl_held_r <= 1'b1;
            sda_held_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[0], scl_sync_r};
            sda_hist_r <= {sda_hist_r[0], sda_sync_r};
            scl_held_r <= scl_filt_s;
            sda_held_r <= sda_filt_s;
        end
    end
`else
    assign scl_filt_s = scl_sync_r;
    assign sda_filt_s = sda_sync_r;
`endif

    assign scl_rise_s  = scl_filt_s & ~scl_prev_r;
    assign scl_fall_s  = ~scl_filt_s & scl_prev_r;
    assign start_s     = scl_filt_s & scl_prev_r & sda_prev_r & ~sda_filt_s;
    assign stop_s      = scl_filt_s & scl_prev_r & ~sda_prev_r & sda_filt_s;
    assign addr_byte_s = {addr_sh_r, sda_filt_s};
    assign rx_byte_s   = {rx_sh_r, sda_filt_s};

    // Next-state and next-output logic for the byte engine.
    always_comb begin
        state_nxt      = state_r;
        cnt_nxt        = cnt_r;
        addr_sh_nxt    = addr_sh_r;
        rx_sh_nxt      = rx_sh_r;
        tx_sh_nxt      = tx_sh_r;
        sda_oe_nxt     = sda_oe_r;
        rx_data_nxt    = rx_data_r;
        rx_valid_nxt   = 1'b0;
        rx_first_nxt   = 1'b0;
        rd_req_nxt     = 1'b0;
        load_nxt       = rd_req_r;
        busy_nxt       = busy_r;
        rw_nxt         = rw_r;
        ack_phase_nxt  = ack_phase_r;
        ack_en_nxt     = ack_en_r;
        first_pend_nxt = first_pend_r;
        if (stop_s) begin
            state_nxt     = IDLE;
            cnt_nxt       = CNT_ZERO;
            sda_oe_nxt    = 1'b0;
            busy_nxt      = 1'b0;
            ack_phase_nxt = 1'b0;
        end else if (start_s) begin
            state_nxt      = ADDR;
            cnt_nxt        = CNT_ZERO;
            sda_oe_nxt     = 1'b0;
            ack_phase_nxt  = 1'b0;
            first_pend_nxt = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_oe_nxt = 1'b0;
                end
                ADDR: begin
                    if (scl_rise_s) begin
                        addr_sh_nxt = addr_byte_s[6:0];
                        if (cnt_r == ADDR_LAST) begin
                            cnt_nxt       = CNT_ZERO;
                            ack_phase_nxt = 1'b0;
                            if (addr_byte_s[7:1] == SLAVE_ADDRESS) begin
                                state_nxt = ADDR_ACK;
                                busy_nxt  = 1'b1;
                                rw_nxt    = addr_byte_s[0];
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else begin
                            cnt_nxt = cnt_r + CNT_ONE;
                        end
                    end else begin
                        addr_sh_nxt = addr_sh_r;
                    end
                end
                ADDR_ACK: begin
                    // First fall starts the ACK pulse, second fall ends it.
                    if (scl_fall_s) begin
                        if (!ack_phase_r) begin
                            sda_oe_nxt    = 1'b1;
                            ack_phase_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt    = 1'b0;
                            ack_phase_nxt = 1'b0;
                            if (rw_r) begin
                                state_nxt  = RD_DATA;
                                rd_req_nxt = 1'b1;
                            end else begin
                                state_nxt = WR_DATA;
                            end
                        end
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                WR_DATA: begin
                    if (scl_rise_s) begin
                        rx_sh_nxt = rx_byte_s[DATA_LENGTH-2:0];
                        if (cnt_r == DATA_LAST) begin
                            cnt_nxt       = CNT_ZERO;
                            state_nxt     = WR_ACK;
                            ack_phase_nxt = 1'b0;
                            if (rx_ready) begin
                                rx_data_nxt    = rx_byte_s;
                                rx_valid_nxt   = 1'b1;
                                rx_first_nxt   = first_pend_r;
                                first_pend_nxt = 1'b0;
                                ack_en_nxt     = 1'b1;
                            end else begin
                                ack_en_nxt = 1'b0;
                            end
                        end else begin
                            cnt_nxt = cnt_r + CNT_ONE;
                        end
                    end else begin
                        rx_sh_nxt = rx_sh_r;
                    end
                end
                WR_ACK: begin
                    if (scl_fall_s) begin
                        if (!ack_phase_r) begin
                            sda_oe_nxt    = ack_en_r;
                            ack_phase_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt    = 1'b0;
                            ack_phase_nxt = 1'b0;
                            state_nxt     = WR_DATA;
                        end
                    end else begin
                        sda_oe_nxt = sda_oe_r;
                    end
                end
                RD_DATA: begin
                    // MSB goes out as soon as the requested byte arrives; the rest follow on falls.
                    if (load_r) begin
                        tx_sh_nxt  = rd_data[DATA_LENGTH-2:0];
                        sda_oe_nxt = ~rd_data[DATA_LENGTH-1];
                    end else if (scl_rise_s) begin
                        if (cnt_r == DATA_LAST) begin
                            cnt_nxt       = CNT_ZERO;
                            state_nxt     = RD_ACK;
                            ack_phase_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt_r + CNT_ONE;
                        end
                    end else if (scl_fall_s) begin
                        sda_oe_nxt = ~tx_sh_r[DATA_LENGTH-2];
                        tx_sh_nxt  = tx_sh_r << 1;
                    end else begin
                        tx_sh_nxt = tx_sh_r;
                    end
                end
                RD_ACK: begin
                    // ack_phase marks that the master ACKed and another byte is wanted.
                    if (scl_rise_s) begin
                        if (sda_filt_s) begin
                            state_nxt = IGNORE;
                        end else begin
                            ack_phase_nxt = 1'b1;
                        end
                    end else if (scl_fall_s) begin
                        sda_oe_nxt = 1'b0;
                        if (ack_phase_r) begin
                            ack_phase_nxt = 1'b0;
                            state_nxt     = RD_DATA;
                            rd_req_nxt    = 1'b1;
                        end else begin
                            ack_phase_nxt = 1'b0;
                        end
                    end else begin
                        ack_phase_nxt = ack_phase_r;
                    end
                end
                IGNORE: begin
                    sda_oe_nxt = 1'b0;
                end
                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge pclk) begin
        if (areset) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            addr_sh_r    <= 7'd0;
            rx_sh_r      <= {(DATA_LENGTH-1){1'b0}};
            tx_sh_r      <= {(DATA_LENGTH-1){1'b0}};
            sda_oe_r     <= 1'b0;
            rx_data_r    <= {DATA_LENGTH{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_first_r   <= 1'b0;
            rd_req_r     <= 1'b0;
            load_r       <= 1'b0;
            busy_r       <= 1'b0;
            rw_r         <= 1'b0;
            ack_phase_r  <= 1'b0;
            ack_en_r     <= 1'b0;
            first_pend_r <= 1'b0;
            scl_prev_r   <= 1'b1;
            sda_prev_r   <= 1'b1;
        end else begin
            state_r      <= state_nxt;
            cnt_r        <= cnt_nxt;
            addr_sh_r    <= addr_sh_nxt;
            rx_sh_r      <= rx_sh_nxt;
            tx_sh_r      <= tx_sh_nxt;
            sda_oe_r     <= sda_oe_nxt;
            rx_data_r    <= rx_data_nxt;
            rx_valid_r   <= rx_valid_nxt;
            rx_first_r   <= rx_first_nxt;
            rd_req_r     <= rd_req_nxt;
            load_r       <= load_nxt;
            busy_r       <= busy_nxt;
            rw_r         <= rw_nxt;
            ack_phase_r  <= ack_phase_nxt;
            ack_en_r     <= ack_en_nxt;
            first_pend_r <= first_pend_nxt;
            scl_prev_r   <= scl_filt_s;
            sda_prev_r   <= sda_filt_s;
        end
    end

    assign sda_oe     = sda_oe_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign rx_first   = rx_first_r;
    assign rd_req     = rd_req_r;
    assign busy       = busy_r;
    assign read_write = rw_r;

endmodule

// File: tb/tb_i2c_target_byte_engine.sv
// Directed I2C master bench for i2c_target_byte_engine with rx/rd scoreboards.
module tb_i2c_target_byte_engine;

    localparam int Q = 10;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
    } rx_exp_t;

    logic       pclk;
    logic       areset;
    logic       scl_i;
    logic       sda_m;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       rx_ready;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       busy;
    logic       read_write;

    int         tests;
    int         fails;
    int         rx_cnt;
    int         rd_cnt;
    int         drv_cnt;
    logic       glitch_en;
    rx_exp_t    exp_rx[$];
    logic [7:0] rd_q[$];

    assign sda_i = sda_m & ~sda_oe;

    i2c_target_byte_engine dut (
        .pclk       (pclk),
        .areset     (areset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .rx_ready   (rx_ready),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .busy       (busy),
        .read_write (read_write)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop expected write bytes, serve read bytes, count SDA drive cycles.
    always @(negedge pclk) begin
        if (sda_oe) drv_cnt++;
        if (rx_valid) begin
            rx_cnt++;
            chk("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
            if (exp_rx.size() > 0) begin
                rx_exp_t e;
                e = exp_rx.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.d));
                chk("rx_first", 32'(rx_first), 32'(e.f));
            end
        end
        if (rd_req) begin
            rd_cnt++;
            chk("rd_pending", 32'(rd_q.size() > 0), 32'd1);
            if (rd_q.size() > 0) rd_data = rd_q.pop_front();
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_i = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_i = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_i = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wait_clk(Q);
        if (glitch_en) begin
            scl_i = 1'b1; wait_clk(1);
            scl_i = 1'b0; wait_clk(Q);
        end
        scl_i = 1'b1; wait_clk(2 * Q);
        scl_i = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clk(Q);
        scl_i = 1'b1; wait_clk(Q);
        b = sda_i;    wait_clk(Q);
        scl_i = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack);
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;
        int         s_rx, s_rd, s_drv;
        tests = 0; fails = 0; rx_cnt = 0; rd_cnt = 0; drv_cnt = 0;
        areset = 1'b1; scl_i = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
        rd_data = 8'h00; glitch_en = 1'b0;
        wait_clk(4);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_first", 32'(rx_first), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read_write", 32'(read_write), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        areset = 1'b0;
        wait_clk(4);

        // Plain write: address, register byte, data byte.
        s_rx = rx_cnt;
        i2c_start();
        write_byte(8'hD0, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_rw", 32'(read_write), 32'd0);
        exp_rx.push_back('{d: 8'h10, f: 1'b1});
        write_byte(8'h10, ack); chk("wr_b0_ack", 32'(ack), 32'd1);
        exp_rx.push_back('{d: 8'hAB, f: 1'b0});
        write_byte(8'hAB, ack); chk("wr_b1_ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_clk(6);
        chk("wr_busy_after_stop", 32'(busy), 32'd0);
        chk("wr_rx_count", 32'(rx_cnt - s_rx), 32'd2);

        // Address mismatch: NACK, then the following byte is ignored.
        s_rx = rx_cnt; s_drv = drv_cnt;
        i2c_start();
        write_byte(8'hA0, ack); chk("mis_addr_nack", 32'(ack), 32'd0);
        chk("mis_busy", 32'(busy), 32'd0);
        write_byte(8'hD0, ack); chk("mis_ignored_ack", 32'(ack), 32'd0);
        chk("mis_no_drive", 32'(drv_cnt - s_drv), 32'd0);
        i2c_stop();
        chk("mis_rx_count", 32'(rx_cnt - s_rx), 32'd0);

        // Read of two bytes, master ACKs the first and NACKs the second.
        s_rd = rd_cnt;
        rd_q.push_back(8'h5A); rd_q.push_back(8'hC3);
        i2c_start();
        write_byte(8'hD1, ack); chk("rd_addr_ack", 32'(ack), 32'd1);
        chk("rd_rw", 32'(read_write), 32'd1);
        read_byte(d, 1'b1); chk("rd_byte0", 32'(d), 32'h5A);
        read_byte(d, 1'b0); chk("rd_byte1", 32'(d), 32'hC3);
        s_drv = drv_cnt;
        for (int i = 0; i < 9; i++) read_bit(b);
        chk("rd_ignore_no_drive", 32'(drv_cnt - s_drv), 32'd0);
        chk("rd_req_count", 32'(rd_cnt - s_rd), 32'd2);
        i2c_stop();

        // Sink stalls on the second data byte.
        s_rx = rx_cnt;
        i2c_start();
        write_byte(8'hD0, ack); chk("bp_addr_ack", 32'(ack), 32'd1);
        exp_rx.push_back('{d: 8'h22, f: 1'b1});
        write_byte(8'h22, ack); chk("bp_b0_ack", 32'(ack), 32'd1);
        rx_ready = 1'b0;
        write_byte(8'h33, ack); chk("bp_b1_nack", 32'(ack), 32'd0);
        rx_ready = 1'b1;
        i2c_stop();
        chk("bp_rx_count", 32'(rx_cnt - s_rx), 32'd1);

        // Repeated START turns a write into a read, then back into a write.
        s_rd = rd_cnt;
        i2c_start();
        write_byte(8'hD0, ack); chk("rs_addr_ack", 32'(ack), 32'd1);
        exp_rx.push_back('{d: 8'h10, f: 1'b1});
        write_byte(8'h10, ack); chk("rs_b0_ack", 32'(ack), 32'd1);
        rd_q.push_back(8'h77);
        i2c_start();
        write_byte(8'hD1, ack); chk("rs_raddr_ack", 32'(ack), 32'd1);
        chk("rs_rw", 32'(read_write), 32'd1);
        read_byte(d, 1'b0); chk("rs_rd_byte", 32'(d), 32'h77);
        chk("rs_rd_req_count", 32'(rd_cnt - s_rd), 32'd1);
        i2c_start();
        write_byte(8'hD0, ack); chk("rs_waddr_ack", 32'(ack), 32'd1);
        exp_rx.push_back('{d: 8'h55, f: 1'b1});
        write_byte(8'h55, ack); chk("rs_first_rearm_ack", 32'(ack), 32'd1);
        i2c_stop();

        // Reset while the target is pulling SDA low during a read byte.
        rd_q.push_back(8'h00);
        i2c_start();
        write_byte(8'hD1, ack); chk("rr_addr_ack", 32'(ack), 32'd1);
        read_bit(b); chk("rr_bit7", 32'(b), 32'd0);
        read_bit(b);
        chk("rr_driving", 32'(sda_oe), 32'd1);
        areset = 1'b1; wait_clk(1);
        areset = 1'b0;
        chk("rr_release", 32'(sda_oe), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        s_drv = drv_cnt;
        for (int i = 0; i < 3; i++) read_bit(b);
        chk("rr_no_drive", 32'(drv_cnt - s_drv), 32'd0);
        i2c_stop();
        i2c_start();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        glitch_en = 1'b1;
`endif
        write_byte(8'hD0, ack); chk("rr_after_addr_ack", 32'(ack), 32'd1);
        glitch_en = 1'b0;
        exp_rx.push_back('{d: 8'h66, f: 1'b1});
        write_byte(8'h66, ack); chk("rr_after_b0_ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_clk(6);

        chk("end_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        chk("end_rd_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
